// File: rtl/sn74xxxx_pkg.sv
// sn74xxxx_pkg: shared defaults and helpers for the SN74xxxx-style logic blocks
//   SN74595_WIDTH_DEFAULT : default shift/storage register width
//   SYNC_STAGES_DEFAULT   : default synchroniser depth for external strobes
//   strobe_latency()      : C edges from first high sample of a strobe to its action
package sn74xxxx_pkg;
   localparam int SN74595_WIDTH_DEFAULT = 8;
   localparam int SYNC_STAGES_DEFAULT = 2;
   function automatic int strobe_latency(input int stages);
      return stages;
   endfunction
endpackage

// File: rtl/strobe_sync_edge.sv
// strobe_sync_edge: synchroniser chain plus edge-history flop for one external strobe
//   C     : system clock, rising edge
//   nR    : asynchronous active-low reset; chain and history load RESET_VAL
//   d     : asynchronous input level
//   level : synchronised level (d itself when STAGES=0)
//   rise  : one-cycle pulse when level goes 0->1
module strobe_sync_edge
   import sn74xxxx_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEFAULT,
   parameter bit RESET_VAL = 1'b0
) (
   input  logic C,
   input  logic nR,
   input  logic d,
   output logic level,
   output logic rise
);
   logic hist;
   if (STAGES == 0) begin : g_bypass
      assign level = d;
   end else begin : g_sync
      logic [STAGES-1:0] stg;
      always_ff @(posedge C or negedge nR)
         if (!nR) stg <= {STAGES{RESET_VAL}};
         else stg <= (stg << 1) | STAGES'(d);
      assign level = stg[STAGES-1];
   end
   always_ff @(posedge C or negedge nR)
      if (!nR) hist <= RESET_VAL;
      else hist <= level;
   assign rise = level & ~hist;
endmodule

// File: rtl/shift_register_74595.sv
// shift_register_74595: single-clock SN74HC595 model (serial-in shift register + storage latch)
//   C       : system clock, rising edge
//   nR      : asynchronous active-low reset
//   ser     : serial data in
//   srclk   : shift strobe, sampled and edge-detected on C
//   rclk    : storage latch strobe, sampled and edge-detected on C
//   srclr_n : shift register clear, active low, synchronised
//   oe_n    : output enable, active low, combinational
//   q       : storage register contents, q[0]=QA
//   q_oe    : drive-enable for q (~oe_n)
//   qh_s    : serial out for cascading, last shift register bit
module shift_register_74595
   import sn74xxxx_pkg::*;
#(
   parameter int WIDTH = SN74595_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic             C,
   input  logic             nR,
   input  logic             ser,
   input  logic             srclk,
   input  logic             rclk,
   input  logic             srclr_n,
   input  logic             oe_n,
   output logic [WIDTH-1:0] q,
   output logic             q_oe,
   output logic             qh_s
);
   logic [WIDTH-1:0] sr, st;
   logic ser_s, srclk_s, rclk_s, clr_s;
   logic ser_rise_unused, clr_rise_unused, srclk_rise, rclk_rise;
   // ser goes through the same depth as srclk so data stays aligned with its strobe
   strobe_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ser (
      .C(C), .nR(nR), .d(ser), .level(ser_s), .rise(ser_rise_unused));
   // strobes reset high so a level held across reset release is not seen as an edge
   strobe_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_srclk (
      .C(C), .nR(nR), .d(srclk), .level(srclk_s), .rise(srclk_rise));
   strobe_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rclk (
      .C(C), .nR(nR), .d(rclk), .level(rclk_s), .rise(rclk_rise));
   strobe_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clr (
      .C(C), .nR(nR), .d(srclr_n), .level(clr_s), .rise(clr_rise_unused));
   // st samples the pre-update sr, so a simultaneous shift or clear is not yet visible
   always_ff @(posedge C or negedge nR)
      if (!nR) begin
         sr <= '0;
         st <= '0;
      end else begin
         if (!clr_s) sr <= '0;
         else if (srclk_rise) sr <= {sr[WIDTH-2:0], ser_s};
         if (rclk_rise) st <= sr;
      end
   assign q = st;
   assign qh_s = sr[WIDTH-1];
   assign q_oe = ~oe_n;
endmodule
